// File: rtl/switch_start_ctrl.sv
// Start-switch front end: per-channel sync + debounce lanes, fixed-priority
// grant gated on controller idle, and begin strobe/level with release lockout.

module ssc_debounce #(
  parameter int CNT_W       = 10,
  parameter int HOLD_CYCLES = 23
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_i,
  output logic stable_o,
  output logic stable_nxt_o
);
  localparam logic [CNT_W-1:0] HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = 1'b0;
    if (sync_q[1]) begin
      cnt_d    = (cnt_q < HOLD) ? cnt_q + 1'b1 : cnt_q;
      stable_d = stable_q | (cnt_q == HOLD_M1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;
endmodule

module switch_start_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 10,
  parameter int HOLD_CYCLES = 23,
  parameter int PULSE_MODE  = 1,
  parameter int SEL_W       = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sw_in,
  input  logic              idle,
  output logic [NUM_CH-1:0] stable_out,
  output logic [NUM_CH-1:0] begin_out,
  output logic [SEL_W-1:0]  sel_ch,
  output logic              busy_lock,
  output logic              err_multi
);
  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_LOCK, S_LEVEL} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] stable_nxt, stable_dly_q, rise;
  logic [NUM_CH-1:0] pending_q, pending_d, grant_mask, new_pend;
  logic [SEL_W-1:0]  sel_q, sel_d, grant_idx;
  logic              grant_vld, seen, multi, err_q, err_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    ssc_debounce #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES)) u_db (
      .clock        (clock),
      .reset        (reset),
      .sw_i         (sw_in[g]),
      .stable_o     (stable_out[g]),
      .stable_nxt_o (stable_nxt[g])
    );
  end

  assign rise     = stable_out & ~stable_dly_q;
  assign new_pend = rise & ~pending_q;

  // Walk high to low so the lowest pending index is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    seen      = 1'b0;
    multi     = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (new_pend[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (idle && grant_vld) begin
          sel_d                 = grant_idx;
          grant_mask[grant_idx] = 1'b1;
          state_d               = (PULSE_MODE != 0) ? S_FIRE : S_LEVEL;
        end
      end
      S_FIRE:  state_d = S_LOCK;
      S_LOCK:  if (!stable_out[sel_q]) state_d = S_IDLE;
      // Leave on the debouncer's next value so begin drops with stable_out.
      S_LEVEL: if (!stable_nxt[sel_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    pending_d = (pending_q | rise) & stable_out & ~grant_mask;
    err_d     = (state_q == S_IDLE) && multi;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      pending_q    <= '0;
      stable_dly_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      stable_dly_q <= stable_out;
      err_q        <= err_d;
    end
  end

  assign begin_out = (state_q == S_FIRE || state_q == S_LEVEL) ?
                     (NUM_CH'(1) << sel_q) : '0;
  assign sel_ch    = sel_q;
  assign busy_lock = (state_q != S_IDLE);
  assign err_multi = err_q;
endmodule

// File: tb/tb_switch_start_ctrl.sv
// Directed bench for switch_start_ctrl: pulse-mode instance for most checks,
// level-mode instance sharing the same stimulus for the hold-while-stable case.
`timescale 1ns/1ps
module tb_switch_start_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw_in = '0;
  logic       idle  = 1'b1;

  logic [1:0] stable_out, begin_out, stable_lvl, begin_lvl;
  logic [0:0] sel_ch, sel_lvl;
  logic       busy_lock, err_multi, busy_lvl, err_lvl;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] seen;

  always #5 clock = ~clock;

  switch_start_ctrl #(.NUM_CH(2), .CNT_W(10), .HOLD_CYCLES(23), .PULSE_MODE(1), .SEL_W(1)) dut (
    .clock(clock), .reset(reset), .sw_in(sw_in), .idle(idle),
    .stable_out(stable_out), .begin_out(begin_out), .sel_ch(sel_ch),
    .busy_lock(busy_lock), .err_multi(err_multi)
  );

  switch_start_ctrl #(.NUM_CH(2), .CNT_W(10), .HOLD_CYCLES(23), .PULSE_MODE(0), .SEL_W(1)) dut_lvl (
    .clock(clock), .reset(reset), .sw_in(sw_in), .idle(idle),
    .stable_out(stable_lvl), .begin_out(begin_lvl), .sel_ch(sel_lvl),
    .busy_lock(busy_lvl), .err_multi(err_lvl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw_in = '0;
    idle  = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_begin",  32'(begin_out),  0);
    chk("rst_stable", 32'(stable_out), 0);
    chk("rst_sel",    32'(sel_ch),     0);
    chk("rst_busy",   32'(busy_lock),  0);
    chk("rst_err",    32'(err_multi),  0);
    tick(2);
    reset = 1'b0;

    // ch0 held 40 cycles: stable at 25, strobe at 27 only
    sw_in = 2'b01;
    tick(24); chk("t1_stable24", 32'(stable_out), 0);
    tick();   chk("t1_stable25", 32'(stable_out), 1);
    tick();   chk("t1_begin26",  32'(begin_out),  0);
    tick();   chk("t1_begin27",  32'(begin_out),  1);
              chk("t1_sel",      32'(sel_ch),     0);
              chk("t1_busy27",   32'(busy_lock),  1);
    tick();   chk("t1_begin28",  32'(begin_out),  0);
              chk("t1_busy28",   32'(busy_lock),  1);
    tick(12);
    sw_in = 2'b00;
    tick(3);  chk("t1_busy_lock", 32'(busy_lock),  1);
              chk("t1_stable_rel", 32'(stable_out), 0);
    tick();   chk("t1_busy_rel",  32'(busy_lock),  0);

    // ch1 single-cycle low glitch restarts the hold count
    do_reset();
    sw_in = 2'b10; tick(20);
    sw_in = 2'b00; tick(1);
    sw_in = 2'b10;
    seen = '0;
    repeat (24) begin tick(); seen |= begin_out; end
    chk("t2_no_begin",  32'(seen),       0);
    chk("t2_stable24",  32'(stable_out), 0);
    tick();  chk("t2_stable25", 32'(stable_out), 2);
    tick(2); chk("t2_begin",    32'(begin_out),  2);
             chk("t2_sel",      32'(sel_ch),     1);
    sw_in = 2'b00; tick(4);
    chk("t2_busy_rel", 32'(busy_lock), 0);

    // simultaneous rise: ch0 first with err_multi, ch1 after ch0 release
    do_reset();
    sw_in = 2'b11;
    tick(25); chk("t3_err25",    32'(err_multi),  0);
              chk("t3_stable",   32'(stable_out), 3);
    tick();   chk("t3_err26",    32'(err_multi),  1);
    tick();   chk("t3_err27",    32'(err_multi),  0);
              chk("t3_begin0",   32'(begin_out),  1);
              chk("t3_sel0",     32'(sel_ch),     0);
    tick();
    sw_in = 2'b10;
    tick(4);  chk("t3_begin_wait", 32'(begin_out), 0);
              chk("t3_sel_hold",   32'(sel_ch),    0);
    tick();   chk("t3_begin1",     32'(begin_out), 2);
              chk("t3_sel1",       32'(sel_ch),    1);
    sw_in = 2'b00; tick(6);

    // idle low holds the request; strobe follows idle rising
    do_reset();
    idle  = 1'b0;
    sw_in = 2'b10;
    tick(30); chk("t4_stable", 32'(stable_out), 2);
    seen = '0;
    repeat (100) begin tick(); seen |= begin_out; end
    chk("t4_no_begin", 32'(seen),      0);
    chk("t4_busy",     32'(busy_lock), 0);
    idle = 1'b1;
    tick(); chk("t4_begin",  32'(begin_out), 2);
    tick(); chk("t4_begin2", 32'(begin_out), 0);
    sw_in = 2'b00; tick(4);

    // level mode: begin held while stable, drops 3 edges after release
    do_reset();
    sw_in = 2'b01;
    tick(26); chk("t5_lvl26",   32'(begin_lvl), 0);
    tick();   chk("t5_lvl27",   32'(begin_lvl), 1);
              chk("t5_lvlbusy", 32'(busy_lvl),  1);
    tick(33); chk("t5_lvl60",   32'(begin_lvl), 1);
    sw_in = 2'b00;
    tick(2);  chk("t5_lvl_f2",    32'(begin_lvl),  1);
    tick();   chk("t5_lvl_f3",    32'(begin_lvl),  0);
              chk("t5_lvl_stab",  32'(stable_lvl), 0);
              chk("t5_lvl_idle",  32'(busy_lvl),   0);

    // reset during FIRE: immediate clear, then a full fresh hold is needed
    do_reset();
    sw_in = 2'b01;
    tick(27); chk("t6_fire", 32'(begin_out), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_begin",  32'(begin_out),  0);
    chk("t6_rst_stable", 32'(stable_out), 0);
    chk("t6_rst_busy",   32'(busy_lock),  0);
    tick(2);
    reset = 1'b0;
    seen = '0;
    repeat (26) begin tick(); seen |= begin_out; end
    chk("t6_no_begin", 32'(seen),       0);
    chk("t6_stable",   32'(stable_out), 1);
    tick(); chk("t6_begin", 32'(begin_out), 1);
    sw_in = 2'b00; tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
